// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and the fetch-stage state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to a fixed value.
module flopenr #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one imem request in flight and holds the
// returned word for decode; redirects squash any outstanding fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready
);

    import riscv_pkg::*;

    fetch_state_e r_state, w_state_next;
    logic         r_kill, w_kill_next;
    logic         r_instr_valid, w_instr_valid_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         w_pc_en;
    logic         w_capture;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_redirect_tgt;
    logic         w_unused_redirect_lo;

    assign w_redirect_tgt       = {redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lo = ^redirect_pc[1:0];
    assign w_pc_inc             = r_pc + 32'd4;

    always_comb begin
        w_state_next       = r_state;
        w_kill_next        = r_kill;
        w_instr_valid_next = r_instr_valid;
        w_pc_next          = r_pc;
        w_pc_en            = 1'b0;
        w_capture          = 1'b0;

        unique case (r_state)
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                    // The accepted request targets the old pc, so its data must be dropped.
                    if (redirect_valid) w_kill_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill || redirect_valid) begin
                        w_kill_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_capture          = 1'b1;
                        w_instr_valid_next = 1'b1;
                        w_state_next       = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    w_instr_valid_next = 1'b0;
                    w_state_next       = S_REQ;
                    if (!redirect_valid) begin
                        w_pc_en   = 1'b1;
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            w_pc_en   = 1'b1;
            w_pc_next = w_redirect_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_kill        <= w_kill_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_pc_en),
        .i_d     (w_pc_next),
        .o_q     (r_pc)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) u_instr_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_capture),
        .i_d     (imem_rsp_data),
        .o_q     (instr)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_pc_out_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_capture),
        .i_d     (r_pc),
        .o_q     (pc_out)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_pc_plus4_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_capture),
        .i_d     (w_pc_inc),
        .o_q     (pc_plus4)
    );

    assign imem_req_valid = (r_state == S_REQ) && !reset;
    assign imem_addr      = r_pc;
    assign instr_valid    = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench: two fetch units (reset pc 0 and FFFF_FFFC) share stimulus.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [1:0][31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_ready;
    logic        rsp_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] rsp_data    [2];
    logic        req_valid   [2];
    logic [31:0] imem_addr   [2];
    logic [31:0] instr       [2];
    logic [31:0] pc_out      [2];
    logic [31:0] pc_plus4    [2];
    logic        instr_valid [2];

    // Reference model state
    item_t       exp_q[$];
    logic [31:0] m_pc    [2];
    logic [31:0] pend_pc [2];
    logic [31:0] rst_pc  [2];
    bit          pending;
    bit          stale;
    bit          after_reset;
    bit          checking;
    int unsigned delay;
    int unsigned lat_max;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid[0]),
        .imem_req_ready (req_ready),
        .imem_addr      (imem_addr[0]),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data[0]),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr[0]),
        .pc_out         (pc_out[0]),
        .pc_plus4       (pc_plus4[0]),
        .instr_valid    (instr_valid[0]),
        .instr_ready    (instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid[1]),
        .imem_req_ready (req_ready),
        .imem_addr      (imem_addr[1]),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data[1]),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr[1]),
        .pc_out         (pc_out[1]),
        .pc_plus4       (pc_plus4[1]),
        .instr_valid    (instr_valid[1]),
        .instr_ready    (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h0001_0013;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // One cycle of stimulus; the model is advanced to the state after the coming edge.
    task automatic step(input bit rst, input bit rq_rdy, input bit in_rdy, input bit redir,
                        input logic [31:0] tgt);
        bit          rsp_fire;
        bit          req_fire;
        bit          hs;
        item_t       it;
        logic [31:0] old_pc [2];
        @(negedge clk);
        reset          = rst;
        req_ready      = rq_rdy;
        instr_ready    = in_rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        rsp_fire       = 1'b0;
        if (!rst && pending && delay == 0) begin
            rsp_valid   = 1'b1;
            rsp_data[0] = mem_word(pend_pc[0]);
            rsp_data[1] = mem_word(pend_pc[1]);
            rsp_fire    = 1'b1;
        end else begin
            // Stray pulses while nothing is outstanding must be ignored.
            rsp_valid   = !pending && ($urandom_range(7) == 0);
            rsp_data[0] = $urandom;
            rsp_data[1] = $urandom;
        end

        if (rst) begin
            exp_q.delete();
            pending     = 1'b0;
            m_pc        = rst_pc;
            after_reset = 1'b1;
        end else begin
            req_fire = !pending && exp_q.size() == 0 && rq_rdy;
            hs       = exp_q.size() != 0 && in_rdy;
            old_pc   = m_pc;
            if (rsp_fire) begin
                pending = 1'b0;
                if (!stale && !redir) begin
                    it.pc[0] = pend_pc[0];
                    it.pc[1] = pend_pc[1];
                    exp_q.push_back(it);
                    after_reset = 1'b0;
                end
            end else if (pending) begin
                if (redir) stale = 1'b1;
                if (delay > 0) delay--;
            end
            if (hs) begin
                it = exp_q.pop_front();
                if (!redir) begin
                    m_pc[0] = it.pc[0] + 32'd4;
                    m_pc[1] = it.pc[1] + 32'd4;
                end
            end
            if (redir) begin
                exp_q.delete();
                m_pc[0] = tgt & 32'hFFFF_FFFC;
                m_pc[1] = tgt & 32'hFFFF_FFFC;
            end
            if (req_fire) begin
                pending = 1'b1;
                pend_pc = old_pc;
                stale   = redir;
                delay   = $urandom_range(lat_max);
            end
        end
    endtask

    // Monitor: compares DUT outputs with the model just after each edge.
    initial begin
        item_t it;
        bit    exp_req;
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                for (int i = 0; i < 2; i++) begin
                    exp_req = !reset && !pending && exp_q.size() == 0;
                    check("instr_valid", i, 32'(instr_valid[i]), 32'(exp_q.size() != 0));
                    check("imem_req_valid", i, 32'(req_valid[i]), 32'(exp_req));
                    if (exp_req) check("imem_addr", i, imem_addr[i], m_pc[i]);
                    if (exp_q.size() != 0) begin
                        it = exp_q[0];
                        check("instr", i, instr[i], mem_word(it.pc[i]));
                        check("pc_out", i, pc_out[i], it.pc[i]);
                        check("pc_plus4", i, pc_plus4[i], it.pc[i] + 32'd4);
                    end else if (after_reset) begin
                        check("reset_instr", i, instr[i], NOP);
                        check("reset_pc_out", i, pc_out[i], 32'h0);
                        check("reset_pc_plus4", i, pc_plus4[i], 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        n_tests        = 0;
        n_fail         = 0;
        checking       = 1'b0;
        rst_pc[0]      = 32'h0000_0000;
        rst_pc[1]      = 32'hFFFF_FFFC;
        m_pc           = rst_pc;
        pending        = 1'b0;
        stale          = 1'b0;
        after_reset    = 1'b1;
        delay          = 0;
        lat_max        = 0;
        reset          = 1'b1;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        rsp_data[0]    = 32'h0;
        rsp_data[1]    = 32'h0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checking = 1'b1;
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Single-cycle memory, sequential stream, then decode stalls.
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (8)  step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4)  step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        lat_max = 2;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(4))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'h0000_0203;
                2:       tgt = 32'hFFFF_FFFC;
                3:       tgt = 32'hFFFF_FFFF;
                default: tgt = $urandom;
            endcase
            step($urandom_range(299) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0,
                 $urandom_range(7) == 0, tgt);
        end

        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        lat_max = 0;
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        @(posedge clk);
        #2;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
